mdu_issue_ctrl: RTL

- Initiator side of the E-stage multiply/divide interface: drives start/ctrl into the MDU and consumes its busy flag.
- Generates the D-stage stall for every HI/LO-touching instruction while a multiply/divide is in flight.
- Suppresses MDU side effects of E-stage instructions flushed by an exception or interrupt.
- Tracks expected MDU latency with its own counter and flags protocol violations.

---
 rtl/mdu_issue_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/mdu_issue_ctrl.sv
// Issue-side controller for the E-stage multiply/divide unit: start/ctrl generation,
// D-stage HI/LO hazard stall and an independent latency tracker that flags protocol errors.
module mdu_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int SLACK   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] op_D,
    input  logic [3:0] op_E,
    input  logic       flush_E,
    input  logic       mdu_busy,
    output logic       mdu_start,
    output logic [3:0] mdu_ctrl,
    output logic       stall_D,
    output logic       inflight,
    output logic       timeout_err
);

    localparam logic [4:0] MUL_LAT_W = 5'(MUL_LAT);
    localparam logic [4:0] DIV_LAT_W = 5'(DIV_LAT);
    localparam logic [4:0] SLACK_W   = 5'(SLACK);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_reg;
    logic [4:0] cnt_reg;
    logic [4:0] overrun_reg;
    logic       start_prev_reg;
    logic       timeout_err_reg;

    logic e_muldiv;
    logic d_hilo;

    assign e_muldiv = (op_E >= 4'd1) && (op_E <= 4'd4);
    assign d_hilo   = (op_D >= 4'd1) && (op_D <= 4'd8);

    // A flushed E-stage op must leave no trace in the MDU, including HI/LO writes.
    assign mdu_ctrl    = flush_E ? 4'd0 : op_E;
    assign mdu_start   = !flush_E && e_muldiv && (state_reg == IDLE);
    assign stall_D     = d_hilo && (mdu_start || mdu_busy || (state_reg != IDLE));
    assign inflight    = (state_reg == RUN);
    assign timeout_err = timeout_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= 5'd0;
            overrun_reg     <= 5'd0;
            start_prev_reg  <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            start_prev_reg <= mdu_start;

            // A new mul/div reaching E while one is tracked means the stall was bypassed.
            if (!flush_E && e_muldiv && (state_reg != IDLE))
                timeout_err_reg <= 1'b1;
            // Busy with nothing launched: the MDU is out of step with the pipeline.
            if (mdu_busy && (state_reg == IDLE) && !start_prev_reg)
                timeout_err_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (mdu_start) begin
                        state_reg   <= RUN;
                        cnt_reg     <= (op_E <= 4'd2) ? MUL_LAT_W : DIV_LAT_W;
                        overrun_reg <= 5'd0;
                    end
                end
                RUN: begin
                    if (cnt_reg != 5'd0) begin
                        cnt_reg <= cnt_reg - 5'd1;
                    end else if (!mdu_busy) begin
                        state_reg   <= IDLE;
                        overrun_reg <= 5'd0;
                    end else if ((overrun_reg + 5'd1) >= SLACK_W) begin
                        // Give up on the MDU so the pipeline cannot deadlock on a stuck busy.
                        timeout_err_reg <= 1'b1;
                        state_reg       <= IDLE;
                        overrun_reg     <= 5'd0;
                    end else begin
                        overrun_reg <= overrun_reg + 5'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
